// File: rtl/pixel_writer_pkg.sv
// Shared definitions for the pixel writer: control FSM encoding and the default
// screen geometry also used by the framebuffer and display modules.
package pixel_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_t;

  localparam int DEF_H_RES = 320;
  localparam int DEF_V_RES = 180;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a fall-through read port (pop_data shows the head entry).
// Push and pop in one cycle are accepted even when full; a push into a full FIFO without a pop is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/triangle_pixel_writer.sv
// Clips fill pixels to the screen, buffers {addr,color} and issues framebuffer writes 3 cycles after sampling.
// Throttles the fill through oe_out, keeping SKID entries free for pixels already in flight.
module triangle_pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int  COORD_WIDTH = 16,
  parameter int  H_RES       = DEF_H_RES,
  parameter int  V_RES       = DEF_V_RES,
  parameter int  COLOR_WIDTH = 16,
  parameter int  FIFO_DEPTH  = 8,
  parameter int  SKID        = 4,
  localparam int ADDR_WIDTH  = $clog2(H_RES * V_RES)
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic signed [COORD_WIDTH-1:0] x_in,
  input  logic signed [COORD_WIDTH-1:0] y_in,
  input  logic                          drawing_in,
  input  logic [COLOR_WIDTH-1:0]        color_in,
  input  logic                          fill_done_in,
  output logic                          oe_out,
  input  logic                          fb_ready_in,
  output logic                          fb_we_out,
  output logic [ADDR_WIDTH-1:0]         fb_addr_out,
  output logic [COLOR_WIDTH-1:0]        fb_data_out,
  output logic                          busy_out,
  output logic                          done_out,
  output logic                          overflow_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_WIDTH + COLOR_WIDTH;

  localparam logic signed [COORD_WIDTH-1:0] X_LIM   = COORD_WIDTH'(H_RES);
  localparam logic signed [COORD_WIDTH-1:0] Y_LIM   = COORD_WIDTH'(V_RES);
  localparam logic [ADDR_WIDTH-1:0]         H_RES_A = ADDR_WIDTH'(H_RES);
  localparam logic [CNT_W-1:0]              OE_LIM  = CNT_W'(FIFO_DEPTH - SKID);

  logic                   in_range;
  logic [ADDR_WIDTH-1:0]  x_a;
  logic [ADDR_WIDTH-1:0]  y_a;
  logic [ADDR_WIDTH-1:0]  addr_c;

  logic                   valid1;
  logic [ADDR_WIDTH-1:0]  addr1;
  logic [COLOR_WIDTH-1:0] color1;

  logic                   fifo_pop;
  logic [ENT_W-1:0]       fifo_q;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;

  state_t                 state_q;
  state_t                 state_d;
  logic                   done_d;

  assign in_range = !x_in[COORD_WIDTH-1] && (x_in < X_LIM) &&
                    !y_in[COORD_WIDTH-1] && (y_in < Y_LIM);

  // Operands are zeroed when off-screen so clipped coordinates never reach the multiplier.
  assign x_a    = in_range ? ADDR_WIDTH'(x_in) : '0;
  assign y_a    = in_range ? ADDR_WIDTH'(y_in) : '0;
  assign addr_c = y_a * H_RES_A + x_a;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid1 <= 1'b0;
      addr1  <= '0;
      color1 <= '0;
    end else begin
      valid1 <= drawing_in && in_range;
      if (drawing_in && in_range) begin
        addr1  <= addr_c;
        color1 <= color_in;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .push      (valid1),
    .push_data ({addr1, color1}),
    .pop       (fifo_pop),
    .pop_data  (fifo_q),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign fifo_pop = !fifo_empty && fb_ready_in;
  assign oe_out   = (fifo_count < OE_LIM);
  assign busy_out = (state_q != IDLE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fb_we_out    <= 1'b0;
      fb_addr_out  <= '0;
      fb_data_out  <= '0;
      overflow_out <= 1'b0;
    end else begin
      fb_we_out <= fifo_pop;
      if (fifo_pop) {fb_addr_out, fb_data_out} <= fifo_q;
      if (valid1 && fifo_full && !fifo_pop) overflow_out <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (drawing_in)        state_d = ACTIVE;
        else if (fill_done_in) done_d  = 1'b1;
      end
      ACTIVE: begin
        if (fill_done_in) state_d = DRAIN;
      end
      DRAIN: begin
        if (!valid1 && fifo_empty && !fifo_pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      done_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_out <= done_d;
    end
  end

endmodule

// File: tb/tb_triangle_pixel_writer.sv
// Directed bench for triangle_pixel_writer: expected writes are queued as pixels are driven
// and compared in order against every fb_we_out pulse.
module tb_triangle_pixel_writer;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  logic               clk_in;
  logic               rst_n_in;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic               drawing_in;
  logic [15:0]        color_in;
  logic               fill_done_in;
  logic               oe_out;
  logic               fb_ready_in;
  logic               fb_we_out;
  logic [15:0]        fb_addr_out;
  logic [15:0]        fb_data_out;
  logic               busy_out;
  logic               done_out;
  logic               overflow_out;

  int   errors = 0;
  int   checks = 0;
  int   n_writes = 0;
  int   n_done = 0;
  exp_t sb[$];
  exp_t mon_e;

  triangle_pixel_writer dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .x_in         (x_in),
    .y_in         (y_in),
    .drawing_in   (drawing_in),
    .color_in     (color_in),
    .fill_done_in (fill_done_in),
    .oe_out       (oe_out),
    .fb_ready_in  (fb_ready_in),
    .fb_we_out    (fb_we_out),
    .fb_addr_out  (fb_addr_out),
    .fb_data_out  (fb_data_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .overflow_out (overflow_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic bit on_screen(input int x, input int y);
    return (x >= 0) && (x < 320) && (y >= 0) && (y < 180);
  endfunction

  task automatic drive_pix(input int x, input int y, input logic [15:0] c, input bit keep);
    exp_t e;
    drawing_in = 1'b1;
    x_in       = 16'(x);
    y_in       = 16'(y);
    color_in   = c;
    if (keep) begin
      e.addr = 16'(y * 320 + x);
      e.data = c;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    step();
    step();
    chk("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic finish_tri();
    int d0;
    d0 = n_done;
    fill_done_in = 1'b1;
    step();
    fill_done_in = 1'b0;
    for (int i = 0; i < 50 && n_done == d0; i++) step();
    chk("done_pulse_count", 32'(n_done - d0), 32'd1);
    step();
    chk("busy_after_done", 32'(busy_out), 32'd0);
  endtask

  always @(negedge clk_in) begin
    if (fb_we_out === 1'b1) begin
      n_writes++;
      chk("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(fb_addr_out), 32'(mon_e.addr));
        chk("wr_data", 32'(fb_data_out), 32'(mon_e.data));
      end
    end
    if (done_out === 1'b1) n_done++;
  end

  initial begin
    int w0;
    int d0;
    int sent;
    int first_low;
    int sent_at_release;
    bit k1;
    bit k2;

    rst_n_in     = 1'b0;
    x_in         = '0;
    y_in         = '0;
    drawing_in   = 1'b0;
    color_in     = '0;
    fill_done_in = 1'b0;
    fb_ready_in  = 1'b0;
    #3;
    chk("rst_we", 32'(fb_we_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_overflow", 32'(overflow_out), 32'd0);
    chk("rst_addr", 32'(fb_addr_out), 32'd0);
    chk("rst_data", 32'(fb_data_out), 32'd0);
    chk("rst_oe", 32'(oe_out), 32'd1);
    repeat (3) step();
    rst_n_in    = 1'b1;
    fb_ready_in = 1'b1;
    step();

    // Single pixel: exact latency and done timing.
    drive_pix(10, 5, 16'hF800, 1'b1);
    @(negedge clk_in);
    chk("sp_busy_n0", 32'(busy_out), 32'd0);
    step();
    drawing_in   = 1'b0;
    fill_done_in = 1'b1;
    @(negedge clk_in);
    chk("sp_busy_n1", 32'(busy_out), 32'd1);
    step();
    fill_done_in = 1'b0;
    @(negedge clk_in);
    chk("sp_we_n2", 32'(fb_we_out), 32'd0);
    step();
    @(negedge clk_in);
    chk("sp_we_n3", 32'(fb_we_out), 32'd1);
    chk("sp_addr_n3", 32'(fb_addr_out), 32'd1610);
    chk("sp_data_n3", 32'(fb_data_out), 32'hF800);
    chk("sp_done_n3", 32'(done_out), 32'd0);
    step();
    @(negedge clk_in);
    chk("sp_done_n4", 32'(done_out), 32'd1);
    chk("sp_we_n4", 32'(fb_we_out), 32'd0);
    chk("sp_busy_n4", 32'(busy_out), 32'd0);
    step();
    @(negedge clk_in);
    chk("sp_done_n5", 32'(done_out), 32'd0);

    // Clipping: only the bottom-right corner is on screen.
    w0 = n_writes;
    step(); drive_pix(-1, 0, 16'h1111, on_screen(-1, 0));
    step(); drive_pix(320, 0, 16'h2222, on_screen(320, 0));
    step(); drive_pix(0, 180, 16'h3333, on_screen(0, 180));
    step(); drive_pix(0, -3, 16'h4444, on_screen(0, -3));
    step(); drive_pix(319, 179, 16'h5555, on_screen(319, 179));
    step(); drawing_in = 1'b0;
    wait_drain(50);
    chk("clip_write_count", 32'(n_writes - w0), 32'd1);
    chk("clip_last_addr", 32'(fb_addr_out), 32'd57599);
    finish_tri();

    // Backpressure: fill reacts to oe_out two cycles late.
    fb_ready_in     = 1'b0;
    sent            = 0;
    first_low       = -1;
    sent_at_release = -1;
    k1              = 1'b1;
    k2              = 1'b1;
    w0              = n_writes;
    for (int cyc = 0; cyc < 300 && sent < 20; cyc++) begin
      step();
      if (cyc == 30) begin
        sent_at_release = sent;
        fb_ready_in     = 1'b1;
      end
      if (!oe_out && first_low < 0) first_low = cyc;
      if (k2) begin
        drive_pix(sent + 3, 2 * sent + 1, 16'(16'hA000 + sent), 1'b1);
        sent++;
      end else begin
        drawing_in = 1'b0;
      end
      k2 = k1;
      k1 = oe_out;
    end
    step();
    drawing_in = 1'b0;
    chk("bp_oe_fall_cycle", 32'(first_low), 32'd5);
    chk("bp_sent_while_stalled", 32'(sent_at_release), 32'd7);
    chk("bp_all_sent", 32'(sent), 32'd20);
    wait_drain(100);
    chk("bp_write_count", 32'(n_writes - w0), 32'd20);
    chk("bp_no_overflow", 32'(overflow_out), 32'd0);
    finish_tri();

    // Overflow: oe_out ignored, only the first 8 pixels fit.
    fb_ready_in = 1'b0;
    w0 = n_writes;
    for (int i = 0; i < 12; i++) begin
      step();
      drive_pix(i + 100, 7, 16'(16'hC000 + i), i < 8);
    end
    step();
    drawing_in = 1'b0;
    step();
    step();
    @(negedge clk_in);
    chk("ov_flag_set", 32'(overflow_out), 32'd1);
    chk("ov_no_write_stalled", 32'(n_writes - w0), 32'd0);
    step();
    fb_ready_in = 1'b1;
    wait_drain(50);
    chk("ov_write_count", 32'(n_writes - w0), 32'd8);
    chk("ov_flag_sticky", 32'(overflow_out), 32'd1);
    finish_tri();

    // Empty triangle.
    step();
    fill_done_in = 1'b1;
    @(negedge clk_in);
    chk("et_done_m0", 32'(done_out), 32'd0);
    step();
    fill_done_in = 1'b0;
    @(negedge clk_in);
    chk("et_done_m1", 32'(done_out), 32'd1);
    chk("et_busy_m1", 32'(busy_out), 32'd0);
    step();
    @(negedge clk_in);
    chk("et_done_m2", 32'(done_out), 32'd0);
    chk("et_busy_m2", 32'(busy_out), 32'd0);

    // Reset while draining five buffered pixels.
    fb_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      drive_pix(i, 50, 16'(16'h0F00 + i), 1'b1);
    end
    step();
    drawing_in   = 1'b0;
    fill_done_in = 1'b1;
    step();
    fill_done_in = 1'b0;
    step();
    step();
    chk("rd_busy_before", 32'(busy_out), 32'd1);
    chk("rd_oe_before", 32'(oe_out), 32'd0);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("rd_we", 32'(fb_we_out), 32'd0);
    chk("rd_done", 32'(done_out), 32'd0);
    chk("rd_busy", 32'(busy_out), 32'd0);
    chk("rd_overflow", 32'(overflow_out), 32'd0);
    chk("rd_addr", 32'(fb_addr_out), 32'd0);
    chk("rd_data", 32'(fb_data_out), 32'd0);
    chk("rd_oe", 32'(oe_out), 32'd1);
    sb.delete();
    w0 = n_writes;
    d0 = n_done;
    fb_ready_in = 1'b1;
    repeat (3) step();
    rst_n_in = 1'b1;
    repeat (20) step();
    chk("rd_no_writes_after", 32'(n_writes - w0), 32'd0);
    chk("rd_no_done_after", 32'(n_done - d0), 32'd0);
    chk("rd_busy_after", 32'(busy_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/triangle_pixel_writer.md
# triangle_pixel_writer

Downstream consumer of the triangle fill stage: accepts the fill's per-pixel (x, y, drawing) stream, clips to the screen, converts to a linear framebuffer address, and buffers in a small FIFO. It throttles the fill through its `oe` input and issues single-cycle writes to the framebuffer port whenever the framebuffer grants access. It reports completion only after the fill's `done` has arrived and every buffered pixel has been written.

## Interface
- `COORD_WIDTH`, 16: signed coordinate width; must match the fill stage.
- `H_RES`, 320: screen width in pixels.
- `V_RES`, 180: screen height in pixels.
- `COLOR_WIDTH`, 16: pixel data width.
- `FIFO_DEPTH`, 8: buffer entries; power of two, ≥ 8.
- `SKID`, 4: free-entry margin reserved for in-flight upstream pixels.
- `ADDR_WIDTH`, `$clog2(H_RES*V_RES)`: framebuffer address width; localparam.
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `x_in`, `y_in`  in  COORD_WIDTH each  signed pixel coordinate from the fill.
- `drawing_in`  in  1  `x_in`/`y_in` valid this cycle.
- `color_in`  in  COLOR_WIDTH  pixel colour, sampled together with each valid pixel.
- `fill_done_in`  in  1  one-cycle pulse from the fill after its last pixel.
- `oe_out`  out  1  output enable to the fill (its `oe`).
- `fb_ready_in`  in  1  framebuffer grants a write in the next cycle.
- `fb_we_out`  out  1  write strobe.
- `fb_addr_out`  out  ADDR_WIDTH  write address.
- `fb_data_out`  out  COLOR_WIDTH  write data.
- `busy_out`  out  1  block holds unfinished work.
- `done_out`  out  1  one-cycle completion pulse.
- `overflow_out`  out  1  sticky error flag; a pixel was dropped because the FIFO was full.

## Operation
- **Stage 1 (clip/address).**
  - On `drawing_in`, register `valid1 = (0 ≤ x < H_RES) && (0 ≤ y < V_RES)`.
  - Compare in signed COORD_WIDTH arithmetic.
  - Compute `addr1 = y*H_RES + x` on in-range values only, truncated to ADDR_WIDTH. No out-of-range value reaches the multiplier result.
  - Register `color1`.
  - Clipped pixels are discarded silently.
- **Stage 2 (buffer).**
  - `valid1` pushes `{addr1, color1}` into the FIFO.
  - A push into a full FIFO is dropped and sets `overflow_out`.
  - `overflow_out` is cleared only by reset.
- **Stage 3 (write).**
  - In any cycle with FIFO not empty and `fb_ready_in` high: pop, and at the next edge register `fb_we_out=1` with the popped address and data.
  - Otherwise `fb_we_out=0` and the address/data registers hold their values.
  - Push and pop in the same cycle are legal, including when the FIFO is full.
- **Throttle.** `oe_out = (count < FIFO_DEPTH - SKID)`, combinational from the registered FIFO count.
- **Control FSM (states IDLE, ACTIVE, DRAIN).**
  - IDLE → ACTIVE on `drawing_in`.
  - ACTIVE → DRAIN on `fill_done_in`.
  - DRAIN → IDLE when stage 1 is empty, the FIFO is empty and no pop is pending. That transition pulses `done_out`.
  - `fill_done_in` in IDLE (empty triangle) pulses `done_out` the next cycle; the state stays IDLE.
  - `busy_out = (state != IDLE)`.
- **Reset mid-operation.** Empties the FIFO, discards stage 1, drops any pending done, and returns the FSM to IDLE.

## Timing
- All outputs except `oe_out` are registered.
- Reset values:
  - `fb_we_out`, `done_out`, `busy_out`, `overflow_out` = 0.
  - `fb_addr_out`, `fb_data_out` = 0.
  - `oe_out` = 1 (FIFO empty).
- **Latency.** Pixel sampled at cycle N with the FIFO empty and `fb_ready_in` high at N+2 gives `fb_we_out` high in cycle N+3.
- **Throughput.** One pixel per cycle sustained while `fb_ready_in` stays high.
- **Framebuffer handshake.** The framebuffer must accept the write in the cycle after it drove `fb_ready_in` high; no stall is possible once the write is issued.
- **Throttle margin.** The fill delivers up to 2 pixels after `oe` falls, and stage 1 holds 1 more. SKID=4 therefore guarantees no overflow.
- **Done latency.** `done_out` rises no earlier than one cycle after the final `fb_we_out` pulse.

## Structure
- **Package `pixel_writer_pkg`:**
  - FSM state enum `{IDLE, ACTIVE, DRAIN}`.
  - Default `H_RES`/`V_RES` constants shared with the framebuffer and display modules.
- **Sub-module `sync_fifo`:**
  - Parameters: width, depth.
  - Ports: push, pop, full, empty, count.
  - Same clock and asynchronous active-low reset as this block.
  - Reused by other rasteriser stages.

## Test plan
- **Single pixel.** Pixel (10,5) with color 16'hF800 → one `fb_we_out` pulse with address 1610 and data F800 three cycles later. `fill_done_in` then gives `done_out` one cycle after that write.
- **Clipping.** Pixels (-1,0), (320,0), (0,180), (0,-3), (319,179) → exactly one write, address 57599.
- **Backpressure.** `fb_ready_in` held low, 20-pixel burst with `oe_out` honoured by a model with a 2-cycle `oe` lag → `oe_out` falls at count 4, no overflow, all 20 writes appear in order once ready rises.
- **Overflow.** Stimulus ignores `oe_out`, 12 pixels pushed with `fb_ready_in` low → `overflow_out`=1, 8 writes emitted in order after ready rises.
- **Empty triangle.** `fill_done_in` with no pixels → `done_out` next cycle; `busy_out` stays 0.
- **Reset mid-drain.** FIFO holds 5 entries, `rst_n_in` asserted asynchronously → all outputs at reset values immediately. No writes and no `done_out` follow after release.
